// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and constants for the systolic skew feeder.
package systolic_skew_feeder_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_ARRAY_SIZE = 4;
  localparam int unsigned RUN_CYCLES         = 3 * DEFAULT_ARRAY_SIZE - 2;

  typedef enum logic [1:0] {
    StLoad,
    StClear,
    StRun,
    StDone
  } state_e;

  // Length of the skewed stream (fill plus flush) for an NxN array.
  function automatic int unsigned run_cycles(input int unsigned n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One buffered lane (a row of A or a column of B). During RUN it emits the
// element at index t-LANE, or zero when that index falls outside the lane.
module systolic_skew_feeder_skew_lane #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned LANE       = 0,
  parameter int unsigned TW         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(ARRAY_SIZE)-1:0] wr_idx,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  input  logic [TW-1:0]                 rd_t,
  output logic [WIDTH-1:0]              elem
);

  localparam int unsigned KW = $clog2(ARRAY_SIZE);

  logic [WIDTH-1:0] mem_q [ARRAY_SIZE];
  logic [WIDTH-1:0] elem_d, elem_q;
  logic [TW-1:0]    rel;

  // Buffer storage; contents are always reloaded before being emitted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Select the skewed element for the upcoming RUN cycle.
  always_comb begin
    elem_d = '0;
    rel    = rd_t - TW'(LANE);
    if (rd_en && (rd_t >= TW'(LANE)) && (rel < TW'(ARRAY_SIZE))) begin
      elem_d = mem_q[KW'(rel)];
    end
  end

  // Registered lane output so the bus has no input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      elem_q <= '0;
    end else begin
      elem_q <= elem_d;
    end
  end

  assign elem = elem_q;

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one A/B operand pair, then drives diagonally skewed edge streams
// into an output-stationary PE array with a clear pulse before and a done
// pulse after the stream.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned ARRAY_SIZE = DEFAULT_ARRAY_SIZE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARRAY_SIZE*WIDTH-1:0]   a_col,
  input  logic [ARRAY_SIZE*WIDTH-1:0]   b_row,
  output logic [ARRAY_SIZE*WIDTH-1:0]   left_bus,
  output logic [ARRAY_SIZE*WIDTH-1:0]   up_bus,
  output logic                          array_clr,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NumRun = run_cycles(ARRAY_SIZE);
  localparam int unsigned KW     = $clog2(ARRAY_SIZE);
  localparam int unsigned TW     = $clog2(NumRun);
  localparam logic [KW-1:0] LastK = KW'(ARRAY_SIZE - 1);
  localparam logic [TW-1:0] LastT = TW'(NumRun - 1);

  state_e        state_d, state_q;
  logic [KW-1:0] k_d, k_q;
  logic [TW-1:0] t_d, t_q;
  logic          accept;
  logic          run_d;
  logic          in_ready_d, in_ready_q;
  logic          clr_d, clr_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;

  // Next-state, beat counter and RUN cycle counter.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    accept  = in_valid && (state_q == StLoad);
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (k_q == LastK) begin
            k_d     = '0;
            state_d = StClear;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StClear: begin
        t_d     = '0;
        state_d = StRun;
      end
      StRun: begin
        if (t_q == LastT) begin
          state_d = StDone;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDone: begin
        k_d     = '0;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    run_d      = (state_d == StRun);
    in_ready_d = (state_d == StLoad);
    clr_d      = (state_d == StClear);
    busy_d     = (state_d != StLoad);
    done_d     = (state_d == StDone);
  end

  // FSM state, counters and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StLoad;
      k_q        <= '0;
      t_q        <= '0;
      in_ready_q <= 1'b1;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      t_q        <= t_d;
      in_ready_q <= in_ready_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign array_clr = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    // Row g of A feeds PE(g,0).left, delayed by g cycles.
    systolic_skew_feeder_skew_lane #(
      .WIDTH      (WIDTH),
      .ARRAY_SIZE (ARRAY_SIZE),
      .LANE       (g),
      .TW         (TW)
    ) u_a_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_idx  (k_q),
      .wr_data (a_col[g*WIDTH +: WIDTH]),
      .rd_en   (run_d),
      .rd_t    (t_d),
      .elem    (left_bus[g*WIDTH +: WIDTH])
    );

    // Column g of B feeds PE(0,g).up, delayed by g cycles.
    systolic_skew_feeder_skew_lane #(
      .WIDTH      (WIDTH),
      .ARRAY_SIZE (ARRAY_SIZE),
      .LANE       (g),
      .TW         (TW)
    ) u_b_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_idx  (k_q),
      .wr_data (b_row[g*WIDTH +: WIDTH]),
      .rd_en   (run_d),
      .rd_t    (t_d),
      .elem    (up_bus[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: drives operand pairs, models a 4x4
// output-stationary PE array on the buses, and scoreboards bus streams,
// done latency and final sums.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NR = 3 * N - 2;

  logic           clk, rst, in_valid, in_ready, array_clr, busy, done;
  logic [N*W-1:0] a_col, b_row, left_bus, up_bus;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [W-1:0] a_m [N][N];
  logic signed [W-1:0] b_m [N][N];

  logic [N*W-1:0] exp_left [$];
  logic [N*W-1:0] exp_up   [$];
  int             exp_sum  [$];
  int             done_cyc [$];
  int             done_cnt = 0;
  int             cyc      = 0;
  int             clr_cyc  = 0;
  int             run_cnt  = -1;
  logic [N*W-1:0] seen_left [NR];

  int                  sum_m [N][N];
  logic signed [W-1:0] h_m   [N][N];
  logic signed [W-1:0] v_m   [N][N];

  systolic_skew_feeder #(
    .WIDTH      (W),
    .ARRAY_SIZE (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .left_bus  (left_bus),
    .up_bus    (up_bus),
    .array_clr (array_clr),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // PE array model: sum += left*up, operands pass right and down.
  function automatic logic signed [W-1:0] pe_left(input int i, input int j);
    if (j == 0) return left_bus[i*W +: W];
    return h_m[i][j-1];
  endfunction

  function automatic logic signed [W-1:0] pe_up(input int i, input int j);
    if (i == 0) return up_bus[j*W +: W];
    return v_m[i-1][j];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          sum_m[i][j] <= 0;
          h_m[i][j]   <= '0;
          v_m[i][j]   <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (array_clr) sum_m[i][j] <= 0;
          else sum_m[i][j] <= sum_m[i][j] + int'(pe_left(i, j)) * int'(pe_up(i, j));
          h_m[i][j] <= pe_left(i, j);
          v_m[i][j] <= pe_up(i, j);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents RUN data or done.
  initial begin
    logic [N*W-1:0] el, eu;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run_cnt = -1;
      end else begin
        cyc++;
        if (array_clr) begin
          clr_cyc = cyc;
          run_cnt = 0;
        end else if (run_cnt >= 0 && run_cnt < NR) begin
          if (exp_left.size() == 0) begin
            check("bus_queue_empty", 64'(exp_left.size()), 64'd1);
          end else begin
            el = exp_left.pop_front();
            eu = exp_up.pop_front();
            check($sformatf("left_bus_t%0d", run_cnt), 64'(left_bus), 64'(el));
            check($sformatf("up_bus_t%0d", run_cnt), 64'(up_bus), 64'(eu));
          end
          check($sformatf("run_flags_t%0d", run_cnt), {62'd0, in_ready, busy}, 64'd1);
          seen_left[run_cnt] = left_bus;
          run_cnt++;
        end
        if (done) begin
          check("done_latency", 64'(cyc - clr_cyc), 64'd11);
          check("done_busy", 64'(busy), 64'd1);
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              if (exp_sum.size() == 0) begin
                check("sum_queue_empty", 64'd0, 64'd1);
              end else begin
                check($sformatf("sum_%0d_%0d", i, j), 64'(sum_m[i][j]),
                      64'(exp_sum.pop_front()));
              end
            end
          end
          done_cyc.push_back(cyc);
          done_cnt++;
          run_cnt = -1;
        end
      end
    end
  end

  task automatic set_mats(input int id);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (id)
          1: begin
            a_m[r][c] = W'(4 * r + c + 1);
            b_m[r][c] = (r == c) ? 8'sd1 : 8'sd0;
          end
          2: begin
            a_m[r][c] = 8'sd127;
            b_m[r][c] = -8'sd128;
          end
          default: begin
            a_m[r][c] = -8'sd1;
            b_m[r][c] = W'(r - c);
          end
        endcase
      end
    end
  endtask

  // Hand-derived final sums for each test pair.
  function automatic int hand_sum(input int id, input int i, input int j);
    case (id)
      1:       return 4 * i + j + 1;
      2:       return -65024;
      default: return -(6 - 4 * j);
    endcase
  endfunction

  task automatic push_expect(input int id);
    logic [N*W-1:0] l, u;
    for (int t = 0; t < NR; t++) begin
      l = '0;
      u = '0;
      for (int e = 0; e < N; e++) begin
        if (t - e >= 0 && t - e < N) begin
          l[e*W +: W] = a_m[e][t-e];
          u[e*W +: W] = b_m[t-e][e];
        end
      end
      exp_left.push_back(l);
      exp_up.push_back(u);
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_sum.push_back(hand_sum(id, i, j));
  endtask

  function automatic logic [N*W-1:0] pack_a(input int k);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = a_m[i][k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] pack_b(input int k);
    logic [N*W-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = b_m[k][j];
    return v;
  endfunction

  // Presents N beats; with toggle, every other cycle carries junk and no valid.
  task automatic send_pair(input int id, input bit toggle);
    int  k = 0;
    int  guard = 0;
    bit  phase = 1'b1;
    set_mats(id);
    push_expect(id);
    while (k < N && guard < 200) begin
      if (toggle && !phase) begin
        in_valid = 1'b0;
        a_col    = $urandom;
        b_row    = $urandom;
      end else begin
        in_valid = 1'b1;
        a_col    = pack_a(k);
        b_row    = pack_b(k);
      end
      @(negedge clk);
      if (in_valid && in_ready) k++;
      phase = !phase;
      @(posedge clk);
      #1;
      guard++;
    end
    n_checks++;
    if (k < N) begin
      n_errors++;
      $display("FAIL send_timeout: got %0d beats accepted, expected %0d", k, N);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g = 0;
    while (done_cnt < target && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    n_checks++;
    if (done_cnt < target) begin
      n_errors++;
      $display("FAIL done_timeout: got %0d done pulses, expected %0d", done_cnt, target);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    check({name, "_left"}, 64'(left_bus), 64'd0);
    check({name, "_up"}, 64'(up_bus), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_clr"}, 64'(array_clr), 64'd0);
  endtask

  task automatic flush_expect();
    exp_left.delete();
    exp_up.delete();
    exp_sum.delete();
  endtask

  initial begin
    int target = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    a_col    = '0;
    b_row    = '0;
    // Reset held with random inputs.
    repeat (5) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom);
      a_col    = $urandom;
      b_row    = $urandom;
    end
    check_idle("rst_hold");
    in_valid = 1'b0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("rst_release");

    // Sequential A, identity B; also hand-check the left-edge skew.
    send_pair(1, 1'b0);
    target++;
    wait_done(target);
    check("skew_t0", 64'(seen_left[0]), 64'h0000_0001);
    check("skew_t3_e3", 64'(seen_left[3][31:24]), 64'd13);
    check("skew_t6", 64'(seen_left[6]), 64'h1000_0000);
    for (int t = 7; t < NR; t++) check($sformatf("skew_t%0d", t), 64'(seen_left[t]), 64'd0);

    // Extreme operands: full-scale accumulation without truncation.
    send_pair(2, 1'b0);
    target++;
    wait_done(target);

    // Toggled in_valid with junk in the idle cycles.
    send_pair(1, 1'b1);
    target++;
    wait_done(target);

    // Back-to-back pairs: the second pair's first beat is held through RUN.
    send_pair(1, 1'b0);
    send_pair(3, 1'b0);
    target += 2;
    wait_done(target);
    check("b2b_gap", 64'(done_cyc[target-1] - done_cyc[target-2]), 64'd16);

    // Reset after a partial load: stale beats must not leak into the next pair.
    set_mats(3);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      a_col    = pack_a(k);
      b_row    = pack_b(k);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_idle("rst_partial");
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of RUN aborts the pair.
    send_pair(2, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_idle("rst_mid_run");
    flush_expect();
    in_valid = 1'b1;
    a_col    = $urandom;
    b_row    = $urandom;
    @(posedge clk);
    #3 rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    send_pair(1, 1'b0);
    target++;
    wait_done(target);
    check("sum_queue_drained", 64'(exp_sum.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
